// File: rtl/fir_coeff_loader_if.sv
// Byte-stream input and coefficient write port of fir_coeff_loader.
// master: the byte source / filter side; slave: the loader itself.
interface fir_coeff_loader_if #(
  parameter int COEFF_SIZE = 16,
  parameter int AW         = 7
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  c_WE;
  logic [COEFF_SIZE-1:0] c_in;
  logic [AW-1:0]         c_addr;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output s_valid, s_data,
    input  s_ready, c_WE, c_in, c_addr, busy, done, err
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, c_WE, c_in, c_addr, busy, done, err
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: parses A5 / K / 2(K+1) payload bytes and writes
// K+1 16-bit coefficients into the filter, holding c_WE high for the whole
// load so the filter stays stalled.
// Optional trailing XOR checksum byte: define FIR_COEFF_CHECKSUM_EN.
//
// state | meaning
// IDLE  | wait for header 0xA5, other bytes dropped
// CNT   | receive K, range-check K+1 against NC
// MSB   | receive high byte of current word
// LSB   | receive low byte, present word on c_in/c_addr
// CHK   | receive checksum byte (FIR_COEFF_CHECKSUM_EN only)
// FIN   | one-cycle end of frame, s_ready low
module fir_coeff_loader #(
  parameter int ORD        = 256,
  parameter int COEFF_SIZE = 16,
  parameter int AW         = $clog2((ORD + 1) >> 1)
) (
  input logic              clk,
  input logic              nrst,
  fir_coeff_loader_if.slave bus
);
  localparam int         NC  = (ORD + 1) >> 1;
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNT  = 3'd1,
    MSB  = 3'd2,
    LSB  = 3'd3,
`ifdef FIR_COEFF_CHECKSUM_EN
    CHK  = 3'd4,
`endif
    FIN  = 3'd5
  } state_t;

  state_t                state;
  logic [7:0]            hi_byte;
  logic [AW-1:0]         idx;
  logic [AW-1:0]         last_idx;
  logic                  s_ready_r;
  logic                  we_r;
  logic [COEFF_SIZE-1:0] c_in_r;
  logic [AW-1:0]         addr_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic                  acc;
`ifdef FIR_COEFF_CHECKSUM_EN
  logic [7:0]            chk_acc;
`endif

  assign acc = bus.s_valid && s_ready_r;

  // Frame parser with registered handshake, write-port and status outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      hi_byte   <= '0;
      idx       <= '0;
      last_idx  <= '0;
      s_ready_r <= 1'b0;
      we_r      <= 1'b0;
      c_in_r    <= '0;
      addr_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
      chk_acc   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          s_ready_r <= 1'b1;
          busy_r    <= 1'b0;
          if (acc && bus.s_data == HDR) begin
            state  <= CNT;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        CNT: begin
          if (acc) begin
            if (int'(bus.s_data) >= NC) begin
              // More words than the filter holds: reject before any write
              err_r  <= 1'b1;
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              last_idx <= AW'(bus.s_data);
              idx      <= '0;
              state    <= MSB;
`ifdef FIR_COEFF_CHECKSUM_EN
              chk_acc  <= bus.s_data;
`endif
            end
          end
        end
        MSB: begin
          if (acc) begin
            hi_byte <= bus.s_data;
            state   <= LSB;
`ifdef FIR_COEFF_CHECKSUM_EN
            chk_acc <= chk_acc ^ bus.s_data;
`endif
          end
        end
        LSB: begin
          if (acc) begin
            we_r    <= 1'b1;
            c_in_r  <= COEFF_SIZE'({hi_byte, bus.s_data});
            addr_r  <= idx;
`ifdef FIR_COEFF_CHECKSUM_EN
            chk_acc <= chk_acc ^ bus.s_data;
`endif
            if (idx != last_idx) begin
              idx   <= idx + AW'(1);
              state <= MSB;
            end else begin
`ifdef FIR_COEFF_CHECKSUM_EN
              state     <= CHK;
`else
              state     <= FIN;
              s_ready_r <= 1'b0;
              done_r    <= 1'b1;
`endif
            end
          end
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        CHK: begin
          if (acc) begin
            state     <= FIN;
            s_ready_r <= 1'b0;
            if (chk_acc == bus.s_data) done_r <= 1'b1;
            else                       err_r  <= 1'b1;
          end
        end
`endif
        FIN: begin
          // Last word is still presented this cycle; release the filter on exit
          state     <= IDLE;
          we_r      <= 1'b0;
          s_ready_r <= 1'b1;
          busy_r    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.c_WE    = we_r;
  assign bus.c_in    = c_in_r;
  assign bus.c_addr  = addr_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
endmodule
